// File: rtl/udma_filter_tx_stream_if.sv
// Bundle of configuration, L2 read port and filter-stream output of the tx stream source.
// The master modport is the stream source; the slave modport is its environment.
interface udma_filter_tx_stream_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned L2_AWIDTH  = 18,
    parameter int unsigned TRANS_SIZE = 16
);
    logic [L2_AWIDTH-1:0]  cfg_start_addr;
    logic [1:0]            cfg_datasize;
    logic                  cfg_mode_2d;
    logic [TRANS_SIZE-1:0] cfg_len0;
    logic [TRANS_SIZE-1:0] cfg_len1;
    logic [TRANS_SIZE-1:0] cfg_stride;
    logic                  cmd_start;
    logic                  busy;
    logic                  done;

    logic                  l2_req;
    logic [L2_AWIDTH-1:0]  l2_addr;
    logic                  l2_gnt;
    logic [DATA_WIDTH-1:0] l2_rdata;
    logic                  l2_rvalid;

    logic [DATA_WIDTH-1:0] output_data;
    logic [1:0]            output_datasize;
    logic                  output_valid;
    logic                  output_sof;
    logic                  output_eof;
    logic                  output_ready;

    modport master (
        input  cfg_start_addr, cfg_datasize, cfg_mode_2d, cfg_len0, cfg_len1, cfg_stride, cmd_start,
        output busy, done,
        output l2_req, l2_addr,
        input  l2_gnt, l2_rdata, l2_rvalid,
        output output_data, output_datasize, output_valid, output_sof, output_eof,
        input  output_ready
    );

    modport slave (
        output cfg_start_addr, cfg_datasize, cfg_mode_2d, cfg_len0, cfg_len1, cfg_stride, cmd_start,
        input  busy, done,
        input  l2_req, l2_addr,
        output l2_gnt, l2_rdata, l2_rvalid,
        input  output_data, output_datasize, output_valid, output_sof, output_eof,
        output output_ready
    );
endinterface

// File: rtl/udma_filter_tx_stream.sv
// Stream source for the uDMA filter: fetches a 1D/2D L2 buffer and emits tagged samples.
// Requests are throttled so that outstanding reads plus buffered samples never exceed the FIFO.
module udma_filter_tx_stream #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned L2_AWIDTH    = 18,
    parameter int unsigned TRANS_SIZE   = 16,
    parameter int unsigned BUFFER_DEPTH = 4
) (
    input logic                    clk,
    input logic                    rst,
    udma_filter_tx_stream_if.master bus
);
    localparam int unsigned PW = $clog2(BUFFER_DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]            state, state_next;

    logic [1:0]            sh_datasize;
    logic                  sh_mode_2d;
    logic [TRANS_SIZE-1:0] sh_len0, sh_len1, sh_stride;

    logic [L2_AWIDTH-1:0]  addr, row_base;
    logic [TRANS_SIZE-1:0] col, row;
    logic                  first_pend;
    logic                  req_q, done_q, busy_q;

    logic [1:0]            sq_off [BUFFER_DEPTH];
    logic [BUFFER_DEPTH-1:0] sq_first, sq_last;
    logic [PW-1:0]         sq_wr, sq_rd;
    logic [CW-1:0]         outstanding;

    logic [DATA_WIDTH-1:0] fq_data [BUFFER_DEPTH];
    logic [BUFFER_DEPTH-1:0] fq_sof, fq_eof;
    logic [CW-1:0]         fq_wr, fq_rd, fifo_count;

    logic                  start_ok, zero_len, grant, pop, valid;
    logic                  row_end, last_elem, last_grant, eof_pop;
    logic [2:0]            sample_bytes;
    logic [L2_AWIDTH-1:0]  next_row_base;
    logic [CW:0]           inflight_next;
    logic [DATA_WIDTH-1:0] rd_shift, rd_mask, push_data;

    assign start_ok      = (state == IDLE) && bus.cmd_start;
    assign zero_len      = (bus.cfg_len0 == '0) || (bus.cfg_mode_2d && (bus.cfg_len1 == '0));
    assign grant         = req_q && bus.l2_gnt;
    assign fifo_count    = fq_wr - fq_rd;
    assign valid         = (fifo_count != '0);
    assign pop           = valid && bus.output_ready;
    assign row_end       = (col == sh_len0 - TRANS_SIZE'(1));
    assign last_elem     = row_end && (!sh_mode_2d || (row == sh_len1 - TRANS_SIZE'(1)));
    assign last_grant    = grant && last_elem;
    assign eof_pop       = pop && fq_eof[fq_rd[PW-1:0]];
    assign next_row_base = row_base + L2_AWIDTH'(sh_stride);
    assign inflight_next = (CW+1)'(outstanding) + (CW+1)'(fifo_count)
                         + (CW+1)'(grant) - (CW+1)'(pop);

    always_comb begin
        sample_bytes = 3'd4;
        rd_mask      = DATA_WIDTH'(32'hFFFF_FFFF);
        case (sh_datasize)
            2'b00: begin sample_bytes = 3'd1; rd_mask = DATA_WIDTH'(32'h0000_00FF); end
            2'b01: begin sample_bytes = 3'd2; rd_mask = DATA_WIDTH'(32'h0000_FFFF); end
            default: ;
        endcase
    end

    // Right-align the addressed byte lane of the returned word
    assign rd_shift  = bus.l2_rdata >> {sq_off[sq_rd], 3'b000};
    assign push_data = rd_shift & rd_mask;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_ok && !zero_len) state_next = RUN;
            RUN:     if (last_grant) state_next = DRAIN;
            DRAIN:   if (eof_pop && (outstanding == '0) && (fifo_count == CW'(1))) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request is recomputed from next-cycle occupancy so it only drops on a grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q  <= 1'b0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            req_q  <= (state_next == RUN) && (inflight_next < (CW+1)'(BUFFER_DEPTH));
            done_q <= (start_ok && zero_len) || ((state == DRAIN) && (state_next == IDLE));
            busy_q <= (state_next != IDLE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_datasize <= 2'b00;
            sh_mode_2d  <= 1'b0;
            sh_len0     <= '0;
            sh_len1     <= '0;
            sh_stride   <= '0;
            addr        <= '0;
            row_base    <= '0;
            col         <= '0;
            row         <= '0;
            first_pend  <= 1'b0;
        end else if (start_ok) begin
            sh_datasize <= bus.cfg_datasize;
            sh_mode_2d  <= bus.cfg_mode_2d;
            sh_len0     <= bus.cfg_len0;
            sh_len1     <= bus.cfg_len1;
            sh_stride   <= bus.cfg_stride;
            addr        <= bus.cfg_start_addr;
            row_base    <= bus.cfg_start_addr;
            col         <= '0;
            row         <= '0;
            first_pend  <= 1'b1;
        end else if (grant) begin
            first_pend <= 1'b0;
            if (sh_mode_2d && row_end) begin
                col      <= '0;
                row      <= row + TRANS_SIZE'(1);
                row_base <= next_row_base;
                addr     <= next_row_base;
            end else begin
                col      <= col + TRANS_SIZE'(1);
                addr     <= addr + L2_AWIDTH'(sample_bytes);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sq_wr       <= '0;
            sq_rd       <= '0;
            outstanding <= '0;
            fq_wr       <= '0;
            fq_rd       <= '0;
        end else begin
            if (grant)         sq_wr <= sq_wr + PW'(1);
            if (bus.l2_rvalid) sq_rd <= sq_rd + PW'(1);
            outstanding <= outstanding + CW'(grant) - CW'(bus.l2_rvalid);
            if (bus.l2_rvalid) fq_wr <= fq_wr + CW'(1);
            if (pop)           fq_rd <= fq_rd + CW'(1);
        end
    end

    // Storage arrays need no reset: pointers alone define occupancy
    always_ff @(posedge clk) begin
        if (grant) begin
            sq_off[sq_wr]   <= addr[1:0];
            sq_first[sq_wr] <= first_pend;
            sq_last[sq_wr]  <= last_elem;
        end
        if (bus.l2_rvalid) begin
            fq_data[fq_wr[PW-1:0]] <= push_data;
            fq_sof[fq_wr[PW-1:0]]  <= sq_first[sq_rd];
            fq_eof[fq_wr[PW-1:0]]  <= sq_last[sq_rd];
        end
    end

    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.l2_req          = req_q;
    assign bus.l2_addr         = {addr[L2_AWIDTH-1:2], 2'b00};
    assign bus.output_valid    = valid;
    assign bus.output_data     = valid ? fq_data[fq_rd[PW-1:0]] : '0;
    assign bus.output_sof      = valid && fq_sof[fq_rd[PW-1:0]];
    assign bus.output_eof      = valid && fq_eof[fq_rd[PW-1:0]];
    assign bus.output_datasize = sh_datasize;

endmodule
